// File: rtl/nack_token_sender.sv
// Transmit end of the forward-token/Nack link.
// Stages payload tokens in a small FIFO and emits a counted burst downstream,
// halting on Nack and resuming only after Nack has stayed low long enough.

package nack_token_sender_pkg;
    // Forward token: valid, last-of-burst marker and payload
    typedef struct packed {
        logic       v;
        logic       r;
        logic [7:0] d;
    } FTk_t;

    // Back-prop token: only the Nack bit is meaningful
    typedef struct packed {
        logic n;
    } BTk_t;
endpackage

module nack_token_sender
    import nack_token_sender_pkg::*;
#(
    parameter int  DEPTH_STAGE = 4,
    parameter int  WIDTH_LEN   = 16,
    parameter int  RESUME_WAIT = 2,
    parameter type TYPE_FWRD   = FTk_t
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Start,
    input  logic [WIDTH_LEN-1:0] I_Len,
    input  TYPE_FWRD             I_Data,
    input  logic                 I_Data_We,
    output logic                 O_Stage_Full,
    output TYPE_FWRD             O_FTk,
    input  BTk_t                 I_BTk,
    output logic                 O_Busy,
    output logic                 O_Done
);

    localparam int AW = $clog2(DEPTH_STAGE);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD,
        DONE
    } state_t;

    state_t               state;
    logic [WIDTH_LEN-1:0] rem;
    logic [1:0]           cnt;
    logic                 busy_q;
    logic                 done_q;

    TYPE_FWRD             mem [DEPTH_STAGE];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;

    logic                 empty;
    logic                 full;
    logic                 issue;
    logic                 push;
    logic                 last;
    TYPE_FWRD             ftk;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH_STAGE));
    assign last  = (rem == WIDTH_LEN'(1));
    // A full FIFO still accepts a write when the head is popped in the same cycle
    assign push  = I_Data_We && (!full || issue);

    // Issue a token only in SEND with Nack low and something staged; Nack acts in the same cycle
    always_comb begin
        issue = 1'b0;
        ftk   = '0;
        if (state == SEND && !I_BTk.n && !empty) begin
            issue = 1'b1;
            ftk   = mem[rd_ptr];
            ftk.v = 1'b1;
            ftk.r = last;
        end
    end

    // Staging storage is not reset; pointers and count define which entries are live
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= I_Data;
        end
    end

    // Staging FIFO pointers and occupancy; reset flushes any staged tokens
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !issue) begin
                count <= count + 1'b1;
            end else if (!push && issue) begin
                count <= count - 1'b1;
            end
        end
    end

    // Burst control: length tracking, Nack hold with glitch filter, registered status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rem    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (I_Start) begin
                        if (I_Len != '0) begin
                            rem    <= I_Len;
                            state  <= SEND;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (issue) begin
                        rem <= rem - 1'b1;
                    end
                    if (issue && last) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (I_BTk.n) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (I_BTk.n) begin
                        cnt <= '0;
                    end else if (cnt == 2'(RESUME_WAIT - 1)) begin
                        cnt   <= '0;
                        state <= SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign O_FTk        = ftk;
    assign O_Stage_Full = full;
    assign O_Busy       = busy_q;
    assign O_Done       = done_q;

endmodule
